// File: rtl/video_timing_pattern_gen_if.sv
// video_timing_pattern_gen_if: control inputs and raster/pixel outputs of the timing generator
interface video_timing_pattern_gen_if;
  logic        pix_en;
  logic [1:0]  pattern_sel;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_start;
  modport master (input pix_en, pattern_sel, output hsync, vsync, de, rgb, x, y, frame_start);
  modport slave (output pix_en, pattern_sel, input hsync, vsync, de, rgb, x, y, frame_start);
endinterface

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: raster timing plus selectable test pattern at pixel rate
module video_timing_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input logic sys_clock,
  input logic sys_nrst,
  video_timing_pattern_gen_if.master vif
);
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] HT    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] HS0   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] VT    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] VS0   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
  // Bar colours, index 0 is the leftmost bar
  localparam logic [7:0][23:0] BARS = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                       24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

  logic [11:0] h_q, h_d, v_q, v_d, x_q, x_d, y_q, y_d;
  logic [23:0] rgb_q, rgb_d;
  logic [1:0]  pat_q, pat_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [2:0]  bar;
  logic        act, h_wrap;

  // Next-state decode of the current (pre-increment) counters; the pattern for the
  // frame_start pixel itself comes from the freshly sampled pattern_sel
  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++) if (h_q >= 12'(i) * BAR_W) bar = 3'(i);
    h_wrap = h_q == HT - 12'd1;
    h_d    = h_wrap ? '0 : h_q + 12'd1;
    v_d    = !h_wrap ? v_q : (v_q == VT - 12'd1) ? '0 : v_q + 12'd1;
    fs_d   = h_q == '0 && v_q == '0;
    pat_d  = fs_d ? vif.pattern_sel : pat_q;
    act    = h_q < HA && v_q < VA;
    de_d   = act;
    x_d    = act ? h_q : '0;
    y_d    = act ? v_q : '0;
    hs_d   = (h_q >= HS0 && h_q < HS1) ? HS_POL : ~HS_POL;
    vs_d   = (v_q >= VS0 && v_q < VS1) ? VS_POL : ~VS_POL;
    rgb_d  = !act ? '0 :
             pat_d == 2'd0 ? BARS[bar] :
             pat_d == 2'd1 ? {3{h_q[7:0]}} :
             pat_d == 2'd2 ? {24{h_q[5] ^ v_q[5]}} : '0;
  end

  // Counters, latched pattern and registered outputs; everything freezes while pix_en is low
  always_ff @(posedge sys_clock or negedge sys_nrst) begin
    if (!sys_nrst) begin
      h_q   <= '0;
      v_q   <= '0;
      pat_q <= '0;
      de_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
      fs_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
    end else if (vif.pix_en) begin
      h_q   <= h_d;
      v_q   <= v_d;
      pat_q <= pat_d;
      de_q  <= de_d;
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
      fs_q  <= fs_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.de          = de_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.rgb         = rgb_q;
  assign vif.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// tb_video_timing_pattern_gen: directed vectors on default timing plus a reduced-timing instance
module tb_video_timing_pattern_gen;
  logic sys_clock = 1'b0;
  logic sys_nrst  = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  video_timing_pattern_gen_if m_if ();
  video_timing_pattern_gen_if s_if ();

  video_timing_pattern_gen dut (
    .sys_clock(sys_clock),
    .sys_nrst (sys_nrst),
    .vif      (m_if)
  );

  // Small raster: 24 x 12 total, 16 x 8 active, active-high syncs
  video_timing_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .sys_clock(sys_clock),
    .sys_nrst (sys_nrst),
    .vif      (s_if)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic [1:0]  pat;
    int          e;
    logic [3:0]  fl;
    logic [11:0] x;
    logic [11:0] y;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic vec_t mv(logic [1:0] p, int e, logic [3:0] fl, logic [11:0] x, logic [11:0] y, logic [23:0] rgb);
    vec_t v;
    v.pat = p; v.e = e; v.fl = fl; v.x = x; v.y = y; v.rgb = rgb;
    return v;
  endfunction

  function automatic logic [63:0] pk(logic [3:0] fl, logic [11:0] x, logic [11:0] y, logic [23:0] rgb);
    return {12'd0, fl, x, y, rgb};
  endfunction

  function automatic logic [63:0] pk_m();
    return pk({m_if.de, m_if.hsync, m_if.vsync, m_if.frame_start}, m_if.x, m_if.y, m_if.rgb);
  endfunction

  function automatic logic [63:0] pk_s();
    return pk({s_if.de, s_if.hsync, s_if.vsync, s_if.frame_start}, s_if.x, s_if.y, s_if.rgb);
  endfunction

  // Expected small-raster outputs after n enabled edges since reset, colour bars selected
  function automatic logic [63:0] model_s(int n);
    int p, h, v;
    logic act;
    if (n == 0) return pk(4'b0000, 12'd0, 12'd0, 24'd0);
    p = n - 1;
    h = p % 24;
    v = (p / 24) % 12;
    act = h < 16 && v < 8;
    return pk({act, h >= 18 && h < 22, v >= 9 && v < 11, p % 288 == 0},
              act ? 12'(h) : 12'd0, act ? 12'(v) : 12'd0, act ? bars[h / 2] : 24'd0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic do_reset();
    sys_nrst = 1'b0;
    @(negedge sys_clock);
    sys_nrst = 1'b1;
  endtask

  initial begin
    int cur;
    logic [1:0] cpat;
    int de_cnt, vs_cnt, hs_cnt, first_vs, first_hs, fs2;
    int nen;
    m_if.pix_en = 1'b0;
    m_if.pattern_sel = 2'd0;
    s_if.pix_en = 1'b0;
    s_if.pattern_sel = 2'd0;
    #1 sys_nrst = 1'b0;
    #2;
    check("reset_main", pk_m(), pk(4'b0110, 12'd0, 12'd0, 24'd0));
    check("reset_small", pk_s(), pk(4'b0000, 12'd0, 12'd0, 24'd0));

    // flags are {de, hsync, vsync, frame_start}; main syncs idle high
    vecs.push_back(mv(2'd0, 1,     4'b1111, 12'd0,   12'd0,  24'hFFFFFF));
    vecs.push_back(mv(2'd0, 2,     4'b1110, 12'd1,   12'd0,  24'hFFFFFF));
    vecs.push_back(mv(2'd0, 80,    4'b1110, 12'd79,  12'd0,  24'hFFFFFF));
    vecs.push_back(mv(2'd0, 81,    4'b1110, 12'd80,  12'd0,  24'hFFFF00));
    vecs.push_back(mv(2'd0, 161,   4'b1110, 12'd160, 12'd0,  24'h00FFFF));
    vecs.push_back(mv(2'd0, 640,   4'b1110, 12'd639, 12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 641,   4'b0110, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 656,   4'b0110, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 657,   4'b0010, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 752,   4'b0010, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 753,   4'b0110, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 800,   4'b0110, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd0, 801,   4'b1110, 12'd0,   12'd1,  24'hFFFFFF));
    vecs.push_back(mv(2'd0, 1121,  4'b1110, 12'd320, 12'd1,  24'hFF00FF));
    vecs.push_back(mv(2'd1, 1,     4'b1111, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd1, 6,     4'b1110, 12'd5,   12'd0,  24'h050505));
    vecs.push_back(mv(2'd1, 301,   4'b1110, 12'd300, 12'd0,  24'h2C2C2C));
    vecs.push_back(mv(2'd2, 32,    4'b1110, 12'd31,  12'd0,  24'h000000));
    vecs.push_back(mv(2'd2, 33,    4'b1110, 12'd32,  12'd0,  24'hFFFFFF));
    vecs.push_back(mv(2'd2, 25601, 4'b1110, 12'd0,   12'd32, 24'hFFFFFF));
    vecs.push_back(mv(2'd2, 25633, 4'b1110, 12'd32,  12'd32, 24'h000000));
    vecs.push_back(mv(2'd3, 1,     4'b1111, 12'd0,   12'd0,  24'h000000));
    vecs.push_back(mv(2'd3, 2,     4'b1110, 12'd1,   12'd0,  24'h000000));

    // Table: reset whenever the pattern changes or the target edge is behind us
    cur = -1;
    cpat = 2'd0;
    m_if.pix_en = 1'b1;
    foreach (vecs[i]) begin
      if (cur < 0 || vecs[i].pat != cpat || vecs[i].e <= cur) begin
        m_if.pattern_sel = vecs[i].pat;
        cpat = vecs[i].pat;
        do_reset();
        cur = 0;
      end
      while (cur < vecs[i].e) begin
        tick();
        cur++;
      end
      check($sformatf("vec%0d", i), pk_m(), pk(vecs[i].fl, vecs[i].x, vecs[i].y, vecs[i].rgb));
    end

    // Asynchronous reset in the middle of line 0
    m_if.pattern_sel = 2'd0;
    do_reset();
    for (int n = 0; n < 301; n++) tick();
    check("pre_async", pk_m(), pk(4'b1110, 12'd300, 12'd0, 24'h00FF00));
    #2 sys_nrst = 1'b0;
    #1;
    check("async_now", pk_m(), pk(4'b0110, 12'd0, 12'd0, 24'd0));
    tick();
    check("async_held", pk_m(), pk(4'b0110, 12'd0, 12'd0, 24'd0));
    @(negedge sys_clock);
    sys_nrst = 1'b1;
    tick();
    check("async_restart", pk_m(), pk(4'b1111, 12'd0, 12'd0, 24'hFFFFFF));
    m_if.pix_en = 1'b0;

    // Small raster: two frames, blanking counts, pattern switch mid-frame
    s_if.pattern_sel = 2'd0;
    s_if.pix_en = 1'b1;
    do_reset();
    de_cnt = 0; vs_cnt = 0; hs_cnt = 0; first_vs = 0; first_hs = 0; fs2 = 0;
    for (int n = 1; n <= 576; n++) begin
      tick();
      if (n <= 288) begin
        if (s_if.de) de_cnt++;
        if (s_if.vsync) vs_cnt++;
        if (s_if.hsync) hs_cnt++;
      end
      if (s_if.vsync && first_vs == 0) first_vs = n;
      if (s_if.hsync && first_hs == 0) first_hs = n;
      if (s_if.frame_start && n > 1 && fs2 == 0) fs2 = n;
      if (n == 1) check("s_first_fs", 64'(s_if.frame_start), 64'd1);
      if (n == 72) s_if.pattern_sel = 2'd1;
      if (n == 102) check("s_bars_kept", pk_s(), pk(4'b1000, 12'd5, 12'd4, 24'h00FFFF));
      if (n == 294) check("s_grey_next", pk_s(), pk(4'b1000, 12'd5, 12'd0, 24'h050505));
    end
    check("s_de_count", 64'(de_cnt), 64'd128);
    check("s_vs_count", 64'(vs_cnt), 64'd48);
    check("s_hs_count", 64'(hs_cnt), 64'd48);
    check("s_first_vs", 64'(first_vs), 64'd217);
    check("s_first_hs", 64'(first_hs), 64'd19);
    check("s_fs_period", 64'(fs2), 64'd289);

    // Small raster with pix_en toggling every cycle against the stall-free model
    s_if.pix_en = 1'b0;
    s_if.pattern_sel = 2'd0;
    do_reset();
    nen = 0;
    for (int i = 0; i < 2000; i++) begin
      s_if.pix_en = (i % 2 == 0);
      tick();
      if (s_if.pix_en) nen++;
      check("stall", pk_s(), model_s(nen));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
